// File: rtl/sig_acq_pkg.sv
// sig_acq_pkg
//   Definitions shared by the signal-acquisition blocks: timer width, default
//   timestamp FIFO geometry and the packed {epoch, count} timestamp entry.
package sig_acq_pkg;

    localparam int TS_COUNT_W     = 32;
    localparam int DEF_EPOCH_W    = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    // One captured timestamp: wrap epoch above the raw timer value.
    typedef struct packed {
        logic [DEF_EPOCH_W-1:0] epoch;
        logic [TS_COUNT_W-1:0]  count;
    } ts_entry_t;

endpackage

// File: rtl/ts_fifo.sv
// ts_fifo
//   Synchronous first-word-fall-through FIFO holding captured timestamps.
//   The head entry is presented on dout in the same cycle valid is high.
//   A push that arrives while the FIFO is full, with no pop on that cycle,
//   is discarded and reported on drop for one cycle.
//
// Ports
//   clk    : clock
//   rst    : asynchronous reset, active low
//   clr    : synchronous flush (has priority over push/pop)
//   push   : write din at the tail
//   pop    : remove the head entry (ignored when empty)
//   din    : entry to write
//   dout   : head entry, zero when empty
//   valid  : FIFO non-empty
//   level  : number of stored entries, 0..DEPTH
//   drop   : push discarded because the FIFO was full
module ts_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;

    logic full;
    logic empty;
    logic push_ok;
    logic pop_ok;

    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LW'(DEPTH));
        pop_ok   = pop & ~empty;
        // At full a simultaneous pop frees the slot the push is about to use.
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop     = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            drop = push & full & ~pop_ok;
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: nothing is read unless level says it was written.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign valid = ~empty;
    assign level = level_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/timestamp_capture.sv
// timestamp_capture
//   Captures {epoch, count} of a free-running 32-bit timer on each rising
//   edge of an asynchronous event line and queues it in a FWFT FIFO.
//   The epoch counts timer wraps so captures remain ordered across wraps.
//
//   Optional build macro EVT_GLITCH_FILTER_EN: adds a run-length filter after
//   the synchronizer; the filtered level only follows the synchronized level
//   after 3 consecutive identical samples (edge latency 5 instead of 3).
//
// Ports
//   clk        : clock, shared with the timer
//   rst        : asynchronous reset, active low
//   clr        : synchronous flush of FIFO, epoch, ovf and edge history
//   ena        : capture enable (also gates epoch counting)
//   count      : free-running timer value
//   pulse_full : one-cycle timer wrap pulse, high while count is already 0
//   evt_in     : asynchronous event line
//   ts_data    : {epoch, count} at the FIFO head
//   ts_valid   : FIFO non-empty
//   ts_ready   : consumer accepts the head entry
//   ts_level   : number of queued entries
//   ovf        : sticky flag, an event was dropped because the FIFO was full
module timestamp_capture
    import sig_acq_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int EPOCH_W    = DEF_EPOCH_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        ena,
    input  logic [TS_COUNT_W-1:0]       count,
    input  logic                        pulse_full,
    input  logic                        evt_in,
    output logic [EPOCH_W+TS_COUNT_W-1:0] ts_data,
    output logic                        ts_valid,
    input  logic                        ts_ready,
    output logic [$clog2(FIFO_DEPTH):0] ts_level,
    output logic                        ovf
);

    localparam int DW = EPOCH_W + TS_COUNT_W;

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               evt_rise_q, evt_rise_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               ovf_q, ovf_d;

    logic [EPOCH_W-1:0] epoch_eff;
    logic               push;
    logic               fifo_drop;

`ifdef EVT_GLITCH_FILTER_EN
    logic       filt_q, filt_d;
    logic [1:0] run_q, run_d;

    // run_q counts consecutive samples that disagree with the filtered level;
    // the third such sample flips it. The edge is taken from filt_d so the
    // filter adds exactly two cycles to the unfiltered path.
    always_comb begin
        filt_d     = filt_q;
        run_d      = '0;
        evt_rise_d = 1'b0;
        if (clr) begin
            filt_d = sync2_q;
        end else begin
            if (sync2_q != filt_q) begin
                if (run_q == 2'd2) begin
                    filt_d = sync2_q;
                end else begin
                    run_d = run_q + 2'd1;
                end
            end
            evt_rise_d = filt_d & ~filt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end
`else
    logic hist_q, hist_d;

    // History always follows the synchronized level, including while ena=0
    // and on clr, so enabling capture never fires on an old edge.
    always_comb begin
        hist_d     = sync2_q;
        evt_rise_d = clr ? 1'b0 : (sync2_q & ~hist_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end
`endif

    always_comb begin
        sync1_d   = evt_in;
        sync2_d   = sync1_q;
        // On the wrap-pulse cycle count has already rolled to 0, so the
        // captured epoch must already include this wrap.
        epoch_eff = epoch_q + {{(EPOCH_W-1){1'b0}}, pulse_full};
        push      = evt_rise_q & ena & ~clr;
        epoch_d   = epoch_q;
        ovf_d     = ovf_q;
        if (clr) begin
            epoch_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (pulse_full && ena) begin
                epoch_d = epoch_q + {{(EPOCH_W-1){1'b0}}, 1'b1};
            end
            if (fifo_drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            evt_rise_q <= 1'b0;
            epoch_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            evt_rise_q <= evt_rise_d;
            epoch_q    <= epoch_d;
            ovf_q      <= ovf_d;
        end
    end

    ts_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (ts_ready),
        .din   ({epoch_eff, count}),
        .dout  (ts_data),
        .valid (ts_valid),
        .level (ts_level),
        .drop  (fifo_drop)
    );

    assign ovf = ovf_q;

endmodule

// File: doc/timestamp_capture.md
TIMESTAMP_CAPTURE -- requirements
Module: timestamp_capture

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of timestamp entries; legal values are a power of 2 from 2 to 64.
REQ-002 SHALL have parameter EPOCH_W, default 16, meaning the width of the wrap-epoch counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock (110.592 MHz domain, shared with the 32-bit timer).
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port clr, input, 1 bit: synchronous flush of all state.
REQ-006 SHALL have port ena, input, 1 bit: capture enable.
REQ-007 SHALL have port count, input, 32 bits: the free-running timer value.
REQ-008 SHALL have port pulse_full, input, 1 bit: the timer wrap pulse, one cycle, registered after count==32'hFFFFFFFF.
REQ-009 SHALL have port evt_in, input, 1 bit: the asynchronous event line.
REQ-010 SHALL have port ts_data, output, EPOCH_W+32 bits: {epoch, count} at the head of the FIFO.
REQ-011 SHALL have port ts_valid, output, 1 bit: the FIFO is non-empty.
REQ-012 SHALL have port ts_ready, input, 1 bit: consumer accept.
REQ-013 SHALL have port ts_level, output, clog2(FIFO_DEPTH)+1 bits: the entry count.
REQ-014 SHALL have port ovf, output, 1 bit: sticky drop flag.

Function
REQ-015 SHALL pass evt_in through a 2-flop synchronizer, then a registered rising-edge detector; evt_rise asserts 3 cycles after the evt_in rising edge is first sampled.
REQ-016 SHALL push {epoch_eff, count} on the cycle evt_rise=1 and ena=1; the count value is the one present on that same cycle.
REQ-017 SHALL define epoch_eff = epoch + pulse_full (modulo 2^EPOCH_W), so a capture on the pulse_full cycle (count already 0) carries the new epoch.
REQ-018 SHALL increment epoch by 1 when pulse_full=1 and ena=1, wrapping from all-ones to 0 with no flag.
REQ-019 SHALL ignore evt_rise when ena=0; the edge detector still tracks, so no stale edge fires when ena rises.
REQ-020 SHALL pop on ts_valid and ts_ready; ts_data is first-word-fall-through, valid in the same cycle ts_valid asserts, with 1-cycle latency from push to ts_valid.
REQ-021 SHALL handle FIFO full and push without pop by dropping the event, setting ovf=1, and leaving the contents unchanged.
REQ-022 SHALL accept both operations when push and pop occur on the same cycle at full; ts_level stays at FIFO_DEPTH and ovf is unchanged.
REQ-023 SHALL ignore ts_ready when empty; ts_level never underflows.
REQ-024 SHALL hold ovf until clr or reset.
REQ-025 SHALL, on clr=1 (priority over push/pop), empty the FIFO, set epoch=0, ovf=0, and clear the edge-detector history to the current synchronized level; the synchronizer flops are not cleared.

Reset
REQ-026 SHALL, while rst=0, drive ts_valid=0, ts_level=0, ovf=0, ts_data=0, epoch=0, and all synchronizer and edge flops to 0.
REQ-027 SHALL discard FIFO contents on reset mid-operation; the first push after release lands in entry 0.

Configuration
REQ-028 SHALL, with EVT_GLITCH_FILTER_EN defined, insert a 3-sample majority-free filter after the synchronizer: the filtered level changes only after 3 consecutive identical synchronized samples, making total edge latency 5 cycles; pulses shorter than 3 cycles are rejected.
REQ-029 SHALL, without EVT_GLITCH_FILTER_EN, omit the filter and keep the latency of REQ-015.

Structure
REQ-030 SHALL place TS_COUNT_W=32, the default EPOCH_W and FIFO_DEPTH, and the ts_entry_t packed type ({epoch, count}) in the shared package sig_acq_pkg.
REQ-031 SHALL implement storage as one sub-module ts_fifo (synchronous FWFT FIFO with level output and push/pop/clr); the synchronizer, filter, edge detection and epoch logic stay in the top level.

Verification
REQ-032 SHALL verify a single capture: ena=1, count ramping, evt_in rising at count=100 -> ts_data={16'd0, 32'd103} (filter off) or 32'd105 (filter on), ts_valid=1, ts_level=1.
REQ-033 SHALL verify wrap: count forced to 32'hFFFFFFFE, pulse_full on the cycle count=0, event captured on that cycle -> ts_data={16'd1, 32'd0}; next wrap -> epoch 2.
REQ-034 SHALL verify overflow: 9 events with ts_ready=0 and depth 8 -> ts_level=8, ovf=1, entries 0-7 intact in order; ovf stays 1 after draining, clears on clr.
REQ-035 SHALL verify simultaneous push and pop at full: ts_ready=1 with evt_rise on the same cycle -> ts_level=8, ovf=0, new entry at tail.
REQ-036 SHALL verify glitch rejection (macro on): a 2-cycle evt_in pulse -> no push; a 4-cycle pulse -> 1 push.
REQ-037 SHALL verify reset mid-stream: 3 entries queued, rst pulsed low -> ts_valid=0 and ts_level=0 immediately; a post-release event -> ts_level=1, epoch 0.
